// File: rtl/ternary_fetch_unit.sv
// Instruction fetch sequencer for the ternary core: reads memory at the PC, holds the
// word for decode and drives the PC update strobe (+1 or a branch offset).
module ternary_fetch_unit #(
  parameter int WORD_SIZE     = 9,
  parameter int MEM_ADDR_SIZE = 4,
  parameter int FETCH_TIMEOUT = 15
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic [2*MEM_ADDR_SIZE-1:0] pc_in,
  output logic                       pc_reset_enable,
  output logic                       pc_update_enable,
  output logic [2*WORD_SIZE-1:0]     pc_value,
  output logic [2*MEM_ADDR_SIZE-1:0] mem_addr,
  output logic                       mem_read_enable,
  input  logic                       mem_ready,
  input  logic [2*WORD_SIZE-1:0]     mem_data,
  output logic [2*WORD_SIZE-1:0]     instr_out,
  output logic [2*MEM_ADDR_SIZE-1:0] instr_pc,
  output logic                       instr_valid,
  input  logic                       instr_ready,
  input  logic                       branch_enable,
  input  logic [2*WORD_SIZE-1:0]     branch_offset,
  input  logic                       halt,
  output logic                       halted,
  output logic                       fault,
  output logic [2:0]                 debug_state
);

  // Trit codes: -1 = 2'b10, 0 = 2'b00, +1 = 2'b01, so an all-zero vector is ternary zero.
  localparam logic [1:0] TRIT_POS = 2'b01;

  localparam logic [2*WORD_SIZE-1:0] PC_PLUS_ONE = {{(2*WORD_SIZE-2){1'b0}}, TRIT_POS};

  localparam int              CNT_W     = $clog2(FETCH_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(FETCH_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_HOLD    = 3'd1,
    S_ADVANCE = 3'd2,
    S_HALTED  = 3'd3,
    S_FAULT   = 3'd4
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  wait_cnt;
  logic              redirect;

  assign pc_reset_enable = ~reset_n;
  assign debug_state     = state;

  // The PC absorbs its update on the same edge that enters FETCH, so the address is taken
  // straight from pc_in; a registered copy would issue the first read one update stale.
  assign mem_addr = pc_in;

  assign redirect = branch_enable &&
                    (state == S_FETCH || state == S_HOLD || state == S_ADVANCE);

  // Decode handshake: instr_valid stays high with instr_out/instr_pc frozen until a cycle
  // with instr_ready=1; that cycle is the transfer, unless branch_enable voids it.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state            <= S_FETCH;
      wait_cnt         <= '0;
      pc_update_enable <= 1'b0;
      pc_value         <= '0;
      mem_read_enable  <= 1'b0;
      instr_out        <= '0;
      instr_pc         <= '0;
      instr_valid      <= 1'b0;
      halted           <= 1'b0;
      fault            <= 1'b0;
    end else begin
      pc_update_enable <= 1'b0;
      if (redirect) begin
        instr_valid      <= 1'b0;
        mem_read_enable  <= 1'b0;
        pc_value         <= branch_offset;
        pc_update_enable <= 1'b1;
        state            <= S_ADVANCE;
      end else begin
        unique case (state)
          S_FETCH: begin
            if (!mem_read_enable) begin
              mem_read_enable <= 1'b1;
            end else if (mem_ready) begin
              instr_out       <= mem_data;
              instr_pc        <= pc_in;
              instr_valid     <= 1'b1;
              mem_read_enable <= 1'b0;
              state           <= S_HOLD;
            end else begin
              wait_cnt <= wait_cnt + CNT_W'(1);
              if (wait_cnt == LAST_WAIT) begin
                fault           <= 1'b1;
                mem_read_enable <= 1'b0;
                state           <= S_FAULT;
              end
            end
          end
          S_HOLD: begin
            if (instr_ready) begin
              instr_valid <= 1'b0;
              if (halt) begin
                halted <= 1'b1;
                state  <= S_HALTED;
              end else begin
                pc_value         <= PC_PLUS_ONE;
                pc_update_enable <= 1'b1;
                state            <= S_ADVANCE;
              end
            end
          end
          S_ADVANCE: begin
            mem_read_enable <= 1'b1;
            wait_cnt        <= '0;
            state           <= S_FETCH;
          end
          S_HALTED: begin
            state <= S_HALTED;
          end
          S_FAULT: begin
            state <= S_FAULT;
          end
          default: begin
            state <= S_FAULT;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ternary_fetch_unit.sv
// Bench for ternary_fetch_unit: PC and memory models around the DUT, a vector table,
// hand-written corner sequences and a randomized run against an architectural PC model.
module tb_ternary_fetch_unit;

  localparam int WS = 9;
  localparam int AS = 4;
  localparam logic [1:0] T_NEG  = 2'b10;
  localparam logic [1:0] T_ZERO = 2'b00;
  localparam logic [1:0] T_POS  = 2'b01;

  logic            clock;
  logic            reset_n;
  logic [2*AS-1:0] pc_in;
  logic            pc_reset_enable;
  logic            pc_update_enable;
  logic [2*WS-1:0] pc_value;
  logic [2*AS-1:0] mem_addr;
  logic            mem_read_enable;
  logic            mem_ready;
  logic [2*WS-1:0] mem_data;
  logic [2*WS-1:0] instr_out;
  logic [2*AS-1:0] instr_pc;
  logic            instr_valid;
  logic            instr_ready;
  logic            branch_enable;
  logic [2*WS-1:0] branch_offset;
  logic            halt;
  logic            halted;
  logic            fault;
  logic [2:0]      dbg_state;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [2*WS-1:0] exp_q[$];

  int              pc_int = -40;
  logic [17:0]     pc_tmp;
  logic [17:0]     mem_words [0:80];
  int              mem_cnt = 0;
  int              mem_lat = 2;
  bit              mem_stall = 0;
  int              exp_pc = -40;

  typedef struct {
    int lat;
    int bp;
    bit br;
    int off;
    int exp_wait;
    int exp_delta;
  } vec_t;
  vec_t vecs [6];

  ternary_fetch_unit #(.WORD_SIZE(WS), .MEM_ADDR_SIZE(AS), .FETCH_TIMEOUT(15)) dut (
    .clock(clock), .reset_n(reset_n), .pc_in(pc_in),
    .pc_reset_enable(pc_reset_enable), .pc_update_enable(pc_update_enable),
    .pc_value(pc_value), .mem_addr(mem_addr), .mem_read_enable(mem_read_enable),
    .mem_ready(mem_ready), .mem_data(mem_data), .instr_out(instr_out),
    .instr_pc(instr_pc), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .branch_enable(branch_enable), .branch_offset(branch_offset), .halt(halt),
    .halted(halted), .fault(fault), .debug_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- helpers ----------------
  function automatic logic [17:0] to_trits(input int v, input int n);
    logic [17:0] t;
    int x, r;
    t = '0;
    x = v;
    for (int i = 0; i < n; i++) begin
      r = ((x % 3) + 3) % 3;
      if (r == 1) begin
        t[2*i +: 2] = T_POS;  x = (x - 1) / 3;
      end else if (r == 2) begin
        t[2*i +: 2] = T_NEG;  x = (x + 1) / 3;
      end else begin
        t[2*i +: 2] = T_ZERO; x = x / 3;
      end
    end
    return t;
  endfunction

  function automatic int from_trits(input logic [17:0] t, input int n);
    int v, w;
    v = 0;
    w = 1;
    for (int i = 0; i < n; i++) begin
      if (t[2*i +: 2] == T_POS) v = v + w;
      else if (t[2*i +: 2] == T_NEG) v = v - w;
      w = w * 3;
    end
    return v;
  endfunction

  function automatic int wrap81(input int v);
    return ((v + 40) % 81 + 81) % 81 - 40;
  endfunction

  function automatic logic [7:0] to_a(input int v);
    logic [17:0] t;
    t = to_trits(v, 4);
    return t[7:0];
  endfunction

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // ---------------- environment: PC register and instruction memory ----------------
  always @(posedge clock) begin
    if (pc_reset_enable) pc_int <= -40;
    else if (pc_update_enable) pc_int <= wrap81(pc_int + from_trits(pc_value, 9));
  end

  always_comb begin
    pc_tmp = to_trits(pc_int, 4);
    pc_in  = pc_tmp[7:0];
  end

  always @(posedge clock) begin
    #1;
    if (mem_read_enable) mem_cnt = mem_cnt + 1;
    else mem_cnt = 0;
    mem_ready = mem_read_enable && !mem_stall && (mem_cnt >= mem_lat);
    if (mem_ready) mem_data = mem_words[from_trits({10'b0, mem_addr}, 4) + 40];
    else mem_data = 18'($urandom());
  end

  // ---------------- driver tasks ----------------
  task automatic wait_valid(input string name);
    int guard;
    guard = 0;
    while (!instr_valid && guard < 40) begin
      tick();
      guard++;
    end
    check(name, 32'(instr_valid), 32'(1));
  endtask

  task automatic run_vec(input vec_t v, input int next_lat, input int id);
    int n, guard, strobes;
    logic prev_ready;
    logic [17:0] held;
    guard = 0;
    while (!mem_read_enable && guard < 20) begin
      tick();
      guard++;
    end
    check($sformatf("v%0d_fetch_start", id), 32'(mem_read_enable), 32'(1));
    check($sformatf("v%0d_mem_addr", id), 32'(mem_addr), 32'(to_a(exp_pc)));
    n = 0;
    prev_ready = 1'b0;
    guard = 0;
    while (!instr_valid && guard < 40) begin
      if (mem_read_enable) n++;
      prev_ready = mem_ready;
      tick();
      guard++;
    end
    check($sformatf("v%0d_wait_cycles", id), n, v.exp_wait);
    check($sformatf("v%0d_valid_after_ready", id), 32'({instr_valid, prev_ready}), 32'(2'b11));
    check($sformatf("v%0d_instr_out", id), 32'(instr_out), 32'(mem_words[exp_pc + 40]));
    check($sformatf("v%0d_instr_pc", id), 32'(instr_pc), 32'(to_a(exp_pc)));
    held = instr_out;
    for (int k = 0; k < v.bp; k++) begin
      tick();
      check($sformatf("v%0d_bp_valid_noreq_nostrobe", id),
            32'({instr_valid, mem_read_enable, pc_update_enable}), 32'(3'b100));
      check($sformatf("v%0d_bp_stable", id), 32'(instr_out), 32'(held));
    end
    mem_lat       = next_lat;
    instr_ready   = 1'b1;
    branch_enable = v.br;
    branch_offset = to_trits(v.off, 9);
    tick();
    instr_ready   = 1'b0;
    branch_enable = 1'b0;
    check($sformatf("v%0d_valid_drop", id), 32'(instr_valid), 32'(0));
    strobes = 0;
    guard = 0;
    while (!mem_read_enable && guard < 10) begin
      if (pc_update_enable) begin
        strobes++;
        check($sformatf("v%0d_pc_value", id), 32'(pc_value), 32'(to_trits(v.exp_delta, 9)));
      end
      tick();
      guard++;
    end
    check($sformatf("v%0d_strobe_count", id), strobes, 1);
    exp_pc = wrap81(exp_pc + v.exp_delta);
  endtask

  task automatic observe_strobe();
    logic [17:0] e;
    if (pc_update_enable) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL r_strobe: got unexpected strobe pc_value=%0h, required no strobe", pc_value);
      end else begin
        e = exp_q.pop_front();
        check("r_strobe_value", 32'(pc_value), 32'(e));
      end
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int n, guard, acts, off, n_hs;
    logic [2:0] s_fetch;
    bit br;

    vecs[0] = '{lat:2, bp:0, br:0, off:0,   exp_wait:2, exp_delta:1};
    vecs[1] = '{lat:1, bp:5, br:0, off:0,   exp_wait:1, exp_delta:1};
    vecs[2] = '{lat:3, bp:0, br:1, off:-4,  exp_wait:3, exp_delta:-4};
    vecs[3] = '{lat:4, bp:2, br:1, off:13,  exp_wait:4, exp_delta:13};
    vecs[4] = '{lat:2, bp:1, br:1, off:100, exp_wait:2, exp_delta:100};
    vecs[5] = '{lat:5, bp:0, br:0, off:0,   exp_wait:5, exp_delta:1};

    for (int i = 0; i < 81; i++) mem_words[i] = to_trits(int'($urandom_range(0, 19682)) - 9841, 9);
    mem_words[0] = {T_POS, T_ZERO, T_NEG, T_ZERO, T_POS, T_ZERO, T_NEG, T_ZERO, T_POS};

    reset_n = 1'b0; instr_ready = 1'b0; branch_enable = 1'b0; branch_offset = '0; halt = 1'b0;
    mem_lat = vecs[0].lat;
    #1;
    check("rst_pc_reset_enable", 32'(pc_reset_enable), 32'(1));
    tick();
    check("rst_ctrl", 32'({pc_update_enable, mem_read_enable, instr_valid, halted, fault}), 32'(0));
    check("rst_instr_out", 32'(instr_out), 32'(0));
    check("rst_instr_pc", 32'(instr_pc), 32'(0));
    check("rst_pc_value", 32'(pc_value), 32'(0));
    check("rst_mem_addr", 32'(mem_addr), 32'(8'b10101010));
    s_fetch = dbg_state;
    tick();
    reset_n = 1'b1;
    exp_pc = -40;

    for (int i = 0; i < 6; i++) run_vec(vecs[i], (i < 5) ? vecs[i+1].lat : 2, i);

    // Branch in FETCH on the same cycle memory answers: the word must be dropped.
    guard = 0;
    while (!mem_ready && guard < 20) begin
      tick();
      guard++;
    end
    check("bf_ready_seen", 32'(mem_ready), 32'(1));
    branch_enable = 1'b1;
    branch_offset = to_trits(7, 9);
    tick();
    branch_enable = 1'b0;
    check("bf_valid_low", 32'(instr_valid), 32'(0));
    check("bf_strobe", 32'({pc_update_enable, mem_read_enable}), 32'(2'b10));
    check("bf_pc_value", 32'(pc_value), 32'(to_trits(7, 9)));
    tick();
    exp_pc = wrap81(exp_pc + 7);
    check("bf_discard", 32'({instr_valid, mem_read_enable}), 32'(2'b01));
    check("bf_refetch_addr", 32'(mem_addr), 32'(to_a(exp_pc)));

    // Halt at the handshake: nothing may move afterwards, not even a branch.
    mem_lat = 1;
    wait_valid("halt_valid");
    check("halt_instr_pc", 32'(instr_pc), 32'(to_a(exp_pc)));
    instr_ready = 1'b1;
    halt = 1'b1;
    tick();
    instr_ready = 1'b0;
    halt = 1'b0;
    check("halt_flags", 32'({halted, instr_valid}), 32'(2'b10));
    acts = 0;
    for (int k = 0; k < 20; k++) begin
      if (pc_update_enable || mem_read_enable || instr_valid) acts++;
      branch_enable = (k == 5);
      branch_offset = to_trits(3, 9);
      tick();
    end
    branch_enable = 1'b0;
    check("halt_quiet_20", acts, 0);
    check("halt_sticky", 32'(halted), 32'(1));
    check("halt_state_distinct", 32'(dbg_state != s_fetch), 32'(1));

    // Reset out of HALTED, then reset again in the middle of HOLD.
    reset_n = 1'b0;
    #1;
    check("rst2_pc_reset_enable", 32'(pc_reset_enable), 32'(1));
    tick();
    reset_n = 1'b1;
    check("rst2_clear", 32'({halted, fault, instr_valid}), 32'(0));
    exp_pc = -40;
    mem_lat = 2;
    wait_valid("hold_valid");
    check("hold_instr_pc", 32'(instr_pc), 32'(to_a(-40)));
    reset_n = 1'b0;
    #1;
    check("hold_rst_pc_reset_enable", 32'(pc_reset_enable), 32'(1));
    tick();
    check("hold_rst_valid", 32'({instr_valid, mem_read_enable}), 32'(0));
    reset_n = 1'b1;

    // Memory never answers: exactly 15 request cycles, then a sticky fault.
    mem_stall = 1'b1;
    n = 0;
    guard = 0;
    while (!fault && guard < 60) begin
      if (mem_read_enable) n++;
      tick();
      guard++;
    end
    check("fault_set", 32'(fault), 32'(1));
    check("fault_wait_cycles", n, 15);
    check("fault_req_drop", 32'(mem_read_enable), 32'(0));
    for (int k = 0; k < 5; k++) begin
      branch_enable = (k == 2);
      tick();
    end
    branch_enable = 1'b0;
    check("fault_sticky", 32'({fault, mem_read_enable, pc_update_enable}), 32'(3'b100));
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check("fault_cleared", 32'(fault), 32'(0));
    mem_stall = 1'b0;
    exp_pc = -40;
    wait_valid("fault_refetch");
    check("fault_refetch_pc", 32'(instr_pc), 32'(to_a(-40)));
    check("fault_refetch_word", 32'(instr_out), 32'(mem_words[0]));

    // Randomized run against the architectural PC model.
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    exp_pc = -40;
    exp_q.delete();
    n_hs = 0;
    for (int c = 0; c < 400; c++) begin
      observe_strobe();
      mem_lat     = int'($urandom_range(1, 4));
      instr_ready = 1'($urandom_range(0, 1));
      br  = !pc_update_enable && ($urandom_range(0, 9) == 0);
      off = int'($urandom_range(0, 200)) - 100;
      branch_enable = br;
      branch_offset = to_trits(off, 9);
      if (br) begin
        exp_pc = wrap81(exp_pc + off);
        exp_q.push_back(to_trits(off, 9));
      end else if (instr_ready && instr_valid) begin
        check("r_instr_out", 32'(instr_out), 32'(mem_words[exp_pc + 40]));
        check("r_instr_pc", 32'(instr_pc), 32'(to_a(exp_pc)));
        exp_pc = wrap81(exp_pc + 1);
        exp_q.push_back(to_trits(1, 9));
        n_hs++;
      end
      tick();
    end
    instr_ready = 1'b0;
    branch_enable = 1'b0;
    for (int k = 0; k < 4; k++) begin
      observe_strobe();
      tick();
    end
    check("r_queue_drained", exp_q.size(), 0);
    check("r_pc_final", pc_int, exp_pc);
    check("r_progress", 32'(n_hs >= 10), 32'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
